// File: rtl/dds_pkg.sv
// dds_pkg: shared types and constants for the DDS waveform generator.
// Holds the wave-select encoding and the configuration register map.
package dds_pkg;

    // Waveform selection, as written to bits [1:0] of the wave register
    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SAW    = 2'd3
    } wave_e;

    // Configuration register addresses
    localparam logic [1:0] REG_FTW  = 2'd0;
    localparam logic [1:0] REG_POFF = 2'd1;
    localparam logic [1:0] REG_WAVE = 2'd2;
    localparam logic [1:0] REG_AMP  = 2'd3;

endpackage

// File: rtl/dds_sine_lut.sv
// dds_sine_lut: quarter-wave sine ROM with a registered read port.
// Entry i holds round((2^(DAC_W-1)-1) * sin(pi/2 * i / 2^LUT_AW)); the
// table is computed at elaboration, so no memory initialisation file is used.
module dds_sine_lut
    import dds_pkg::*;
#(
    parameter int LUT_AW = 8,
    parameter int DAC_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LUT_AW-1:0] addr,
    output logic [DAC_W-1:0]  data
);

    localparam int DEPTH = 32'sd1 << LUT_AW;

    // Rounded quarter-wave sample for table index idx
    function automatic logic [DAC_W-1:0] sine_entry(input int idx);
        real peak;
        real angle;
        peak  = real'((32'sd1 <<< (DAC_W - 1)) - 32'sd1);
        angle = 3.14159265358979 / 2.0 * real'(idx) / real'(DEPTH);
        return DAC_W'($rtoi(peak * $sin(angle) + 0.5));
    endfunction

    logic [DAC_W-1:0] rom_s [DEPTH];
    logic [DAC_W-1:0] data_r;

    for (genvar g = 32'sd0; g < DEPTH; g++) begin : g_rom
        assign rom_s[g] = sine_entry(g);
    end

    // Synchronous ROM read; cleared on reset so no stale sample survives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r <= '0;
        end else begin
            data_r <= rom_s[addr];
        end
    end

    assign data = data_r;

endmodule

// File: rtl/dds_waveform_gen.sv
// dds_waveform_gen: direct-digital-synthesis core producing unsigned DAC
// samples (sine, square, triangle, saw) with amplitude scaling and a
// phase-wrap sync pulse.
// Pipeline: S0 accumulator, S1 phase offset + LUT address, S2 LUT read /
// shaping, S3 multiply, S4 output register (acc at cycle n -> dac at n+4).
// Build option: define DDS_SINE_LUT_EN to build the sine ROM; without it
// wave 0 produces s=0 (midscale output) and no LUT is instantiated.
module dds_waveform_gen
    import dds_pkg::*;
#(
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 8,
    parameter int DAC_W   = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [PHASE_W-1:0] cfg_wdata,
    input  logic               run,
    output logic [DAC_W-1:0]   dac_data,
    output logic               dac_valid,
    output logic               sync_out
);

    localparam logic [DAC_W-1:0]        MIDSCALE = {1'b1, {(DAC_W-1){1'b0}}};
    localparam logic signed [DAC_W-1:0] FULL_POS = {1'b0, {(DAC_W-1){1'b1}}};
    localparam logic signed [DAC_W-1:0] FULL_NEG = -FULL_POS;

    // Configuration and accumulator state
    logic [PHASE_W-1:0] ftw_r;
    logic [PHASE_W-1:0] poff_r;
    logic [PHASE_W-1:0] acc_r;
    logic [PHASE_W-1:0] acc_sum_s;
    logic               carry_s;
    logic               xfer_s;
    logic               wrap_r;
    wave_e              wave_sh_r;
    wave_e              wave_act_r;
    wave_e              wave_sh_next_s;
    logic [DAC_W-1:0]   amp_sh_r;
    logic [DAC_W-1:0]   amp_act_r;
    logic [DAC_W-1:0]   amp_sh_next_s;

    // S1
    logic [PHASE_W-1:0] p_s;
    logic [LUT_AW-1:0]  lut_addr_s;
    logic [LUT_AW-1:0]  lut_addr_s1_r;
    logic [DAC_W:0]     p_top_s1_r;
    wave_e              wave_s1_r;
    logic [DAC_W-1:0]   amp_s1_r;
    logic               valid_s1_r;
    logic               sync_s1_r;

    // S2
    logic [DAC_W-1:0]        tri_t_s;
    logic [DAC_W-1:0]        saw_t_s;
    logic signed [DAC_W-1:0] shape_s;
    logic signed [DAC_W-1:0] shape_s2_r;
    logic [DAC_W-1:0]        lut_data_s;
    logic                    neg_s2_r;
    wave_e                   wave_s2_r;
    logic [DAC_W-1:0]        amp_s2_r;
    logic                    valid_s2_r;
    logic                    sync_s2_r;

    // S3
    logic signed [DAC_W-1:0]   s_s;
    logic signed [2*DAC_W-1:0] prod_s;
    logic signed [DAC_W-1:0]   scaled_s3_r;
    logic                      valid_s3_r;
    logic                      sync_s3_r;

    // S4
    logic [DAC_W-1:0] dac_data_r;
    logic             dac_valid_r;
    logic             sync_r;

    // Shadow-register next values; a write in a wrap cycle is forwarded so
    // the wrap transfer captures it
    always_comb begin
        wave_sh_next_s = wave_sh_r;
        amp_sh_next_s  = amp_sh_r;
        if (cfg_we) begin
            case (cfg_addr)
                REG_WAVE: wave_sh_next_s = wave_e'(cfg_wdata[1:0]);
                REG_AMP:  amp_sh_next_s  = cfg_wdata[DAC_W-1:0];
                default: begin
                    wave_sh_next_s = wave_sh_r;
                    amp_sh_next_s  = amp_sh_r;
                end
            endcase
        end else begin
            wave_sh_next_s = wave_sh_r;
            amp_sh_next_s  = amp_sh_r;
        end
    end

    // Accumulator sum with carry; active copies load on wrap or while idle
    always_comb begin
        {carry_s, acc_sum_s} = {1'b0, acc_r} + {1'b0, ftw_r};
        xfer_s               = ~run | carry_s;
    end

    // Configuration registers and their shadow/active copies
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ftw_r      <= '0;
            poff_r     <= '0;
            wave_sh_r  <= WAVE_SINE;
            wave_act_r <= WAVE_SINE;
            amp_sh_r   <= '0;
            amp_act_r  <= '0;
        end else begin
            if (cfg_we && (cfg_addr == REG_FTW)) begin
                ftw_r <= cfg_wdata;
            end
            if (cfg_we && (cfg_addr == REG_POFF)) begin
                poff_r <= cfg_wdata;
            end
            wave_sh_r <= wave_sh_next_s;
            amp_sh_r  <= amp_sh_next_s;
            if (xfer_s) begin
                wave_act_r <= wave_sh_next_s;
                amp_act_r  <= amp_sh_next_s;
            end
        end
    end

    // S0: phase accumulator, held at zero while stopped; wrap flag rides with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r  <= '0;
            wrap_r <= 1'b0;
        end else if (run) begin
            acc_r  <= acc_sum_s;
            wrap_r <= carry_s;
        end else begin
            acc_r  <= '0;
            wrap_r <= 1'b0;
        end
    end

    // Offset phase and mirrored quarter-wave address (odd quadrants read backwards)
    always_comb begin
        p_s = acc_r + poff_r;
        if (p_s[PHASE_W-2]) begin
            lut_addr_s = ~p_s[PHASE_W-3 -: LUT_AW];
        end else begin
            lut_addr_s = p_s[PHASE_W-3 -: LUT_AW];
        end
    end

    // S1: register offset phase, LUT address and the settings this sample uses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_top_s1_r    <= '0;
            lut_addr_s1_r <= '0;
            wave_s1_r     <= WAVE_SINE;
            amp_s1_r      <= '0;
            valid_s1_r    <= 1'b0;
            sync_s1_r     <= 1'b0;
        end else begin
            p_top_s1_r    <= p_s[PHASE_W-1 -: DAC_W+1];
            lut_addr_s1_r <= lut_addr_s;
            wave_s1_r     <= wave_act_r;
            amp_s1_r      <= amp_act_r;
            valid_s1_r    <= run;
            sync_s1_r     <= wrap_r & run;
        end
    end

`ifdef DDS_SINE_LUT_EN
    dds_sine_lut #(
        .LUT_AW (LUT_AW),
        .DAC_W  (DAC_W)
    ) u_sine_lut (
        .clk   (clk),
        .reset (reset),
        .addr  (lut_addr_s1_r),
        .data  (lut_data_s)
    );
`else
    logic unused_lut_s;
    assign lut_data_s   = '0;
    assign unused_lut_s = ^lut_addr_s1_r;
`endif

    // Non-sine shapes: square, triangle and saw as signed samples
    always_comb begin
        saw_t_s = p_top_s1_r[DAC_W -: DAC_W];
        if (p_top_s1_r[DAC_W]) begin
            tri_t_s = ~p_top_s1_r[DAC_W-1:0];
        end else begin
            tri_t_s = p_top_s1_r[DAC_W-1:0];
        end
        case (wave_s1_r)
            WAVE_SQUARE: shape_s = p_top_s1_r[DAC_W] ? FULL_NEG : FULL_POS;
            WAVE_TRI:    shape_s = {~tri_t_s[DAC_W-1], tri_t_s[DAC_W-2:0]};
            WAVE_SAW:    shape_s = {~saw_t_s[DAC_W-1], saw_t_s[DAC_W-2:0]};
            default:     shape_s = '0;
        endcase
    end

    // S2: shaped sample and the sign needed for the LUT output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shape_s2_r <= '0;
            neg_s2_r   <= 1'b0;
            wave_s2_r  <= WAVE_SINE;
            amp_s2_r   <= '0;
            valid_s2_r <= 1'b0;
            sync_s2_r  <= 1'b0;
        end else begin
            shape_s2_r <= shape_s;
            neg_s2_r   <= p_top_s1_r[DAC_W];
            wave_s2_r  <= wave_s1_r;
            amp_s2_r   <= amp_s1_r;
            valid_s2_r <= valid_s1_r;
            sync_s2_r  <= sync_s1_r;
        end
    end

    // Select sine or shaped sample, then multiply by the unsigned amplitude
    always_comb begin
        if (wave_s2_r == WAVE_SINE) begin
            if (neg_s2_r) begin
                s_s = -$signed(lut_data_s);
            end else begin
                s_s = $signed(lut_data_s);
            end
        end else begin
            s_s = shape_s2_r;
        end
        prod_s = $signed({{DAC_W{s_s[DAC_W-1]}}, s_s}) *
                 $signed({{DAC_W{1'b0}}, amp_s2_r});
    end

    // S3: floor(prod / 2^DAC_W) is the upper half of the two's-complement product
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scaled_s3_r <= '0;
            valid_s3_r  <= 1'b0;
            sync_s3_r   <= 1'b0;
        end else begin
            scaled_s3_r <= prod_s[2*DAC_W-1:DAC_W];
            valid_s3_r  <= valid_s2_r;
            sync_s3_r   <= sync_s2_r;
        end
    end

    // S4: add midscale offset (MSB flip) or park at midscale when not valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dac_data_r  <= MIDSCALE;
            dac_valid_r <= 1'b0;
            sync_r      <= 1'b0;
        end else begin
            if (valid_s3_r) begin
                dac_data_r <= {~scaled_s3_r[DAC_W-1], scaled_s3_r[DAC_W-2:0]};
            end else begin
                dac_data_r <= MIDSCALE;
            end
            dac_valid_r <= valid_s3_r;
            sync_r      <= sync_s3_r;
        end
    end

    // Low phase bits and the discarded product fraction are intentionally dropped
    logic unused_bits_s;
    assign unused_bits_s = ^{p_s[PHASE_W-DAC_W-2:0], prod_s[DAC_W-1:0]};

    assign dac_data  = dac_data_r;
    assign dac_valid = dac_valid_r;
    assign sync_out  = sync_r;

endmodule

// File: doc/dds_waveform_gen.md
# dds_waveform_gen

Direct-digital-synthesis core of the signal generator. It runs on the PLL's primary output clock, `clk0_out`, and turns a configurable frequency tuning word into a stream of unsigned DAC samples. Four waveforms are available: sine, square, triangle and sawtooth. Amplitude scaling is applied, and a phase-wrap sync pulse is produced for scope triggering. Configuration comes from an already-synchronised register-write port.

## Interface
- `PHASE_W`, default 32: phase accumulator width.
- `LUT_AW`, default 8: quarter-wave sine LUT address width (2^LUT_AW entries).
- `DAC_W`, default 10: DAC sample width.
- `clk`  in  1: sample clock, driven from the PLL's clk0_out; single clock domain.
- `reset`  in  1: asynchronous, active-high reset.
- `cfg_we`  in  1: register write strobe, one cycle per write.
- `cfg_addr`  in  2: register select.
- `cfg_wdata`  in  PHASE_W: write data.
- `run`  in  1: enables accumulation and output.
- `dac_data`  out  DAC_W: unsigned sample to the DAC.
- `dac_valid`  out  1: dac_data carries a live sample.
- `sync_out`  out  1: one-cycle pulse aligned with the first sample after a phase wrap.

## Operation
Registers:
- 0: FTW. Takes effect immediately.
- 1: phase offset POFF. Takes effect immediately.
- 2: wave select, bits [1:0]: 0 sine, 1 square, 2 triangle, 3 saw. Shadowed.
- 3: amplitude AMP, bits [DAC_W-1:0]. Shadowed.
- Registers 2 and 3 are written into shadow copies. The shadow copies transfer to the active copies only on a phase-wrap cycle, or while run=0, so waveform and amplitude changes are glitch-free.

Accumulator:
- While run=1: acc <= acc + FTW (mod 2^PHASE_W). The carry out is the wrap flag.
- While run=0: acc is held at 0.
- cfg_we together with a wrap in the same cycle: the new FTW applies from the next cycle. A shadow write in that same cycle is captured by the wrap.

Phase shaping, with P = acc + POFF:
- ph = P[PHASE_W-1 -: LUT_AW+2]. The top 2 bits of ph give the quadrant q; i = the lower LUT_AW bits.
- Sine: LUT holds round((2^(DAC_W-1)-1)·sin(π/2·i/2^LUT_AW)).
  - Address is i for q = 0 and 2, and ~i for q = 1 and 3.
  - Result is negated for q = 2 and 3.
- Square: s = ±(2^(DAC_W-1)-1), positive when P MSB=0.
- Saw: s = P[PHASE_W-1 -: DAC_W] − 2^(DAC_W-1).
- Triangle: take t = P[PHASE_W-2 -: DAC_W], bit-inverted when P MSB=1; then s = t − 2^(DAC_W-1).

Scaling and output:
- s is signed, DAC_W bits.
- scaled = (s·AMP) >>> DAC_W, an arithmetic (floor) shift.
- dac_data = scaled + 2^(DAC_W-1). No clamp is needed.
- dac_valid is run delayed by the pipeline latency.
- When dac_valid=0, dac_data = 2^(DAC_W-1) (midscale).

## Timing
- Reset values:
  - acc, FTW, POFF, wave (active and shadow) and AMP (active and shadow) = 0.
  - dac_data = 2^(DAC_W-1).
  - dac_valid = 0 and sync_out = 0.
- Pipeline stages:
  - S0: accumulator.
  - S1: add POFF and form the LUT address.
  - S2: registered LUT read / shape.
  - S3: multiply.
  - S4: output register.
- Latency: the acc value at cycle n appears on dac_data at cycle n+4. The wrap flag travels alongside it, so sync_out is asserted at n+4.
- run 0→1: the first valid sample is phase 0, with dac_valid high 4 cycles later.
- run 1→0: acc clears the next cycle. The in-flight samples then drain, and dac_valid drops 4 cycles after run falls.
- Reset mid-stream: all state returns to the reset values at once, with no partial samples.

## Configuration
- `DDS_SINE_LUT_EN` defined: the sine LUT sub-module is instantiated and wave 0 produces sine.
- `DDS_SINE_LUT_EN` undefined: no LUT is built. Wave 0 gives s=0, so dac_data is held at midscale while the other waves are unaffected.

## Structure
- Package `dds_pkg` holds:
  - the wave-select enum (WAVE_SINE, WAVE_SQUARE, WAVE_TRI, WAVE_SAW);
  - the register address constants (REG_FTW, REG_POFF, REG_WAVE, REG_AMP).
- Sub-module `dds_sine_lut`: a synchronous-read quarter-wave ROM, initialised from the formula at elaboration. Only one instance is used.

## Test plan
All scenarios use DAC_W=10.
- FTW=2^28, run=1: sync_out pulses exactly every 16 cycles, with the first pulse 4 cycles after the first wrap.
- Square, AMP=1023: dac_data alternates 1022 / 1, 8 samples each at FTW=2^28.
- Sine, AMP=1023, FTW=2^30, POFF=0: dac_data repeats 512, 1022, 512, 1.
- AMP rewritten from 1023 to 511 mid-period: the output amplitude changes only on the sample flagged by sync_out, never before.
- Reset asserted with run=1: outputs go to 512/0/0 immediately. After release with run=1, the first valid sample is phase 0.
- `DDS_SINE_LUT_EN` undefined, wave 0: dac_data=512 constant with dac_valid=1. Switching to square gives 1022/1.
